// File: rtl/demux_sched_pkg.sv
// Shared constants and state encoding for the 1x8 demux round-robin scheduler.
package demux_sched_pkg;

  localparam int unsigned NCH  = 8;
  localparam int unsigned SELW = 3;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One-hot channel mask for a select index
  function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] idx);
    return NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_1x8_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 8.
module rr_pick_8
  import demux_sched_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  // Walk from the farthest candidate back to ptr so the nearest set bit wins
  always_comb begin
    idx = ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[ptr + SELW'(i)]) idx = ptr + SELW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/demux_1x8_sched.sv
// Round-robin scheduler sharing one valid/ready stream across 8 demux channels.
module demux_1x8_sched
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW        = 1,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [SELW-1:0] sel,
  output logic [NCH-1:0]  gnt,
  output logic            busy,
  output logic [NCH-1:0]  out_valid,
  output logic [DW-1:0]   out_data
);

  state_e          r_state;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_ptr;
  logic [NCH-1:0]  r_gnt;
  logic [NCH-1:0]  r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;

  logic            w_any;
  logic [SELW-1:0] w_idx;
  logic            w_req_sel;
  logic            w_xfer;
  logic            w_last;

  rr_pick_8 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Ready follows the granted channel's request only; in_valid never gates it
  assign w_req_sel = req[r_sel];
  assign in_ready  = (r_state == GRANT) && w_req_sel;
  assign w_xfer    = in_ready && in_valid;
  assign w_last    = (r_cnt == CNTW'(MAX_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_idx;
            r_gnt   <= onehot(w_idx);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            r_out_valid <= r_gnt;
            r_out_data  <= in_data;
            r_cnt       <= r_cnt + CNTW'(1);
          end
          // Rotate on a dropped request or once the beat budget is spent
          if (!w_req_sel || (w_xfer && w_last)) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_sel + SELW'(1);
            r_state <= GAP;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
  a_ready_in_grant : assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> (r_state == GRANT));
  a_ov_follows_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid == '0) || (r_out_valid == $past(r_gnt)));

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a model.
module tb_demux_1x8_sched;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       in_valid = 1'b0;
  logic [0:0] in_data = '0;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic [7:0] out_valid;
  logic [0:0] out_data;

  always #5 clk = ~clk;

  demux_1x8_sched #(.DW(1), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sel(sel), .gnt(gnt), .busy(busy),
    .out_valid(out_valid), .out_data(out_data)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: who owns the stream, whether a dead cycle is pending, rotation pointer
  int m_owner, m_ptr, m_beats, m_sel, m_ov, m_od;
  bit m_gap;

  function automatic bit has(input logic [7:0] r, input int c);
    return ((r >> c) & 8'h1) != 8'h0;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_beats = 0; m_sel = 0; m_ov = 0; m_od = 0;
  endtask

  task automatic m_step(input logic [7:0] r, input bit v, input bit d);
    int  nov;
    bit  leave;
    bit  found;
    nov = 0; leave = 0; found = 0;
    if (m_owner >= 0) begin
      if (!has(r, m_owner)) leave = 1;
      else if (v) begin
        nov = 1 << m_owner; m_od = int'(d); m_beats++;
        if (m_beats == MAXB) leave = 1;
      end
      if (leave) begin
        m_ptr = (m_owner + 1) % 8; m_owner = -1; m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (r != 8'h0) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && has(r, (m_ptr + k) % 8)) begin
          found = 1; m_owner = (m_ptr + k) % 8; m_sel = m_owner; m_beats = 0;
        end
      end
    end
    m_ov = nov;
  endtask

  // One clock: drive at negedge, compare after settling, advance the model
  task automatic tick(input logic [7:0] r, input bit v, input bit d);
    @(negedge clk);
    req = r; in_valid = v; in_data = d;
    #1;
    chk("sel", int'(sel), m_sel);
    chk("gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    chk("in_ready", int'(in_ready), (m_owner >= 0) ? int'(has(r, m_owner)) : 0);
    chk("out_valid", int'(out_valid), m_ov);
    chk("out_data", int'(out_data), m_od);
    m_step(r, v, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 8'hFF; in_valid = 1'b1; in_data = 1'b1;
    m_reset();
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    req = '0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g[16];
  int gn;

  // Record the channel of each new grant until 'want' grants or the budget expires
  task automatic collect(input logic [7:0] r, input int want, input int budget);
    int prev;
    prev = 0; gn = 0;
    for (int c = 0; c < budget && gn < want; c++) begin
      tick(r, 1'b1, 1'($urandom_range(1)));
      if (gnt != 8'h0 && prev == 0) begin g[gn] = int'(sel); gn++; end
      prev = int'(gnt);
    end
    if (gn < want) chk("grant_timeout", gn, want);
  endtask

  typedef struct {
    bit v; bit d;
    int sel; int gnt; int busy; int ir; int ov; int od;
  } vec_t;

  function automatic vec_t mk(input bit v, input bit d, input int s, input int gt,
                              input int b, input int ir, input int ov, input int od);
    vec_t x;
    x.v = v; x.d = d; x.sel = s; x.gnt = gt; x.busy = b; x.ir = ir; x.ov = ov; x.od = od;
    return x;
  endfunction

  vec_t tbl[10];

  initial begin
    int acc[10], ovs[10], bsy[10];
    int pat[10];
    int pulses, mism, exp_rr[3], exp_ff[9];

    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 3, 8, 1, 1, 0, 0);
    tbl[2] = mk(1, 0, 3, 8, 1, 1, 8, 1);
    tbl[3] = mk(1, 1, 3, 8, 1, 1, 8, 0);
    tbl[4] = mk(1, 1, 3, 8, 1, 1, 8, 1);
    tbl[5] = mk(1, 0, 3, 0, 0, 0, 8, 1);
    tbl[6] = mk(1, 0, 3, 0, 0, 0, 0, 1);
    tbl[7] = mk(1, 0, 3, 8, 1, 1, 0, 1);
    tbl[8] = mk(0, 0, 3, 8, 1, 1, 8, 0);
    tbl[9] = mk(0, 0, 3, 8, 1, 1, 0, 0);

    do_reset();
    tick(8'h00, 1'b0, 1'b0);
    tick(8'h00, 1'b1, 1'b1);

    // Single channel 3: four-beat burst, two-cycle gap, re-grant for the fifth beat
    do_reset();
    foreach (tbl[i]) begin
      tick(8'h08, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_sel", i), int'(sel), tbl[i].sel);
      chk($sformatf("tbl%0d_gnt", i), int'(gnt), tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), tbl[i].ir);
      chk($sformatf("tbl%0d_ov", i), int'(out_valid), tbl[i].ov);
      chk($sformatf("tbl%0d_od", i), int'(out_data), tbl[i].od);
    end

    // Reset asserted mid-burst clears every output at once
    tick(8'h08, 1'b1, 1'b1);
    tick(8'h08, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_od", int'(out_data), 0);
    m_reset();
    req = '0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 1'b1, 1'b1);
      chk("post_rst_ov", int'(out_valid), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    // Round-robin wrap between channels 0 and 7
    do_reset();
    exp_rr = '{0, 7, 0};
    collect(8'h81, 3, 60);
    for (int i = 0; i < 3; i++) chk($sformatf("rr_wrap%0d", i), g[i], exp_rr[i]);

    // Request drop on channel 5 after two beats hands over to channel 6
    do_reset();
    tick(8'h60, 1'b1, 1'b1);
    tick(8'h60, 1'b1, 1'b1);
    chk("drop_gnt5", int'(gnt), 8'h20);
    tick(8'h60, 1'b1, 1'b0);
    tick(8'h40, 1'b1, 1'b1);
    chk("drop_ready", int'(in_ready), 0);
    chk("drop_beat2", int'(out_valid), 8'h20);
    tick(8'h40, 1'b1, 1'b1);
    chk("drop_no_third", int'(out_valid), 0);
    chk("drop_gap_gnt", int'(gnt), 0);
    tick(8'h40, 1'b1, 1'b1);
    tick(8'h40, 1'b1, 1'b1);
    chk("drop_sel6", int'(sel), 6);
    chk("drop_gnt6", int'(gnt), 8'h40);

    // Backpressure on channel 2: only accepted beats count toward rotation
    do_reset();
    pat = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      tick(8'h04, 1'(pat[i]), 1'(i & 1));
      acc[i] = int'(in_ready & in_valid);
      ovs[i] = int'(out_valid);
      bsy[i] = int'(busy);
    end
    pulses = 0; mism = 0;
    for (int i = 1; i < 10; i++) begin
      if (ovs[i] != 0) pulses++;
      if ((ovs[i] != 0) != (acc[i-1] != 0)) mism++;
    end
    chk("bp_pulses", pulses, 4);
    chk("bp_latency", mism, 0);
    chk("bp_rotate_busy", bsy[7], 0);
    chk("bp_regrant_busy", bsy[9], 1);

    // All requesting with ptr=4: grants walk 4..7, 0..3, 4
    do_reset();
    collect(8'h08, 1, 20);
    chk("ff_pre_sel", int'(sel), 3);
    for (int i = 0; i < 3; i++) tick(8'h08, 1'b1, 1'b0);
    exp_ff = '{4, 5, 6, 7, 0, 1, 2, 3, 4};
    collect(8'hFF, 9, 200);
    for (int i = 0; i < 9; i++) chk($sformatf("ff_order%0d", i), g[i], exp_ff[i]);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [7:0] r;
      r = req;
      if ($urandom_range(3) == 0) r = 8'($urandom);
      tick(r, $urandom_range(3) != 0, 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
